// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared access-size and FSM state types for the data memory controller
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_D = 2'b11
    } size_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SPLIT = 1'b1
    } state_e;

endpackage

// File: rtl/dmem_ram_bank.sv
// rtl/dmem_ram_bank.sv - single-port byte-enabled RAM with registered read (read-first)
module dmem_ram_bank #(
    parameter int AddressWidth = 10,
    parameter int DataWidth    = 32
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [DataWidth/8-1:0]    be_i,
    input  logic [AddressWidth-1:0]   addr_i,
    input  logic [DataWidth-1:0]      wdata_i,
    output logic [DataWidth-1:0]      rdata_o
);

    logic [DataWidth-1:0] mem_q [2**AddressWidth];
    logic [DataWidth-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < DataWidth / 8; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - load/store data memory controller with sized, extended accesses
// Optional two-beat misaligned access support is enabled by defining DMEM_MISALIGN_SPLIT_EN.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int AddressWidth = 10,
    parameter int DataWidth    = 32
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         req_valid_i,
    output logic                                         req_ready_o,
    input  logic                                         req_we_i,
    input  logic [1:0]                                   req_size_i,
    input  logic                                         req_unsigned_i,
    input  logic [AddressWidth+$clog2(DataWidth/8)-1:0]  req_addr_i,
    input  logic [DataWidth-1:0]                         req_wdata_i,
    output logic                                         rsp_valid_o,
    output logic [DataWidth-1:0]                         rsp_rdata_o,
    output logic                                         rsp_err_o
);

    localparam int ByteW = DataWidth / 8;
    localparam int OffW  = $clog2(ByteW);

`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    size_e                   req_size;
    logic [OffW-1:0]         req_off;
    logic [AddressWidth-1:0] req_word;
    logic [2*ByteW-1:0]      bmask, be_win;
    logic [OffW-1:0]         lowmask;
    logic [2*DataWidth-1:0]  wdata_win;
    logic                    illegal, misalign, err, do_split, accept;

    state_e                  state_q, state_d;
    logic                    rsp_pend_q, rsp_pend_d, rsp_err_q, rsp_err_d, rsp_split_q, rsp_split_d;
    logic                    cap_we_q, cap_we_d, cap_uns_q, cap_uns_d;
    size_e                   cap_size_q, cap_size_d;
    logic [OffW-1:0]         cap_off_q, cap_off_d;
    logic [AddressWidth-1:0] hi_word_q, hi_word_d;
    logic [ByteW-1:0]        hi_be_q, hi_be_d;
    logic [DataWidth-1:0]    hi_wdata_q, hi_wdata_d, rd_lo_q, rd_lo_d;

    logic                    ram_we;
    logic [ByteW-1:0]        ram_be;
    logic [AddressWidth-1:0] ram_addr;
    logic [DataWidth-1:0]    ram_wdata, ram_rdata, merged, ext;
    logic                    fill;
    int                      nbits;

    assign req_size = size_e'(req_size_i);
    assign req_off  = req_addr_i[OffW-1:0];
    assign req_word = req_addr_i[AddressWidth+OffW-1:OffW];

    // The access is viewed through a two-word window so one shift covers both beats.
    always_comb begin
        bmask   = '0;
        lowmask = '0;
        case (req_size)
            SZ_B:    bmask[0] = 1'b1;
            SZ_H:    begin bmask[1:0] = '1; lowmask[0] = 1'b1; end
            SZ_W:    begin bmask[3:0] = '1; lowmask[1:0] = '1; end
            default: begin bmask[ByteW-1:0] = '1; lowmask = '1; end
        endcase
    end

    assign illegal   = (req_size == SZ_D) && (DataWidth == 32);
    assign misalign  = |(req_off & lowmask);
    assign err       = illegal || (misalign && !SplitEn);
    assign do_split  = misalign && !illegal && SplitEn;
    assign be_win    = bmask << req_off;
    assign wdata_win = {{DataWidth{1'b0}}, req_wdata_i} << {req_off, 3'b000};

    assign req_ready_o = !rst_i && (state_q == ST_IDLE);
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        ram_addr  = req_word;
        ram_be    = be_win[ByteW-1:0];
        ram_wdata = wdata_win[DataWidth-1:0];
        ram_we    = accept && req_we_i && !err;
        if (state_q == ST_SPLIT) begin
            ram_addr  = hi_word_q;
            ram_be    = hi_be_q;
            ram_wdata = hi_wdata_q;
            ram_we    = cap_we_q && !rst_i;
        end
    end

    always_comb begin
        state_d     = state_q;
        rsp_pend_d  = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_split_d = 1'b0;
        cap_we_d    = cap_we_q;
        cap_uns_d   = cap_uns_q;
        cap_size_d  = cap_size_q;
        cap_off_d   = cap_off_q;
        hi_word_d   = hi_word_q;
        hi_be_d     = hi_be_q;
        hi_wdata_d  = hi_wdata_q;
        rd_lo_d     = rd_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cap_we_d   = req_we_i;
                    cap_uns_d  = req_unsigned_i;
                    cap_size_d = req_size;
                    cap_off_d  = req_off;
                    hi_word_d  = req_word + AddressWidth'(1);
                    hi_be_d    = be_win[2*ByteW-1:ByteW];
                    hi_wdata_d = wdata_win[2*DataWidth-1:DataWidth];
                    if (do_split) begin
                        state_d = ST_SPLIT;
                    end else begin
                        rsp_pend_d = 1'b1;
                        rsp_err_d  = err;
                    end
                end
            end
            ST_SPLIT: begin
                state_d     = ST_IDLE;
                rsp_pend_d  = 1'b1;
                rsp_split_d = 1'b1;
                rd_lo_d     = ram_rdata;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rsp_pend_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_split_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_pend_q  <= rsp_pend_d;
            rsp_err_q   <= rsp_err_d;
            rsp_split_q <= rsp_split_d;
        end
    end

    always_ff @(posedge clk_i) begin
        cap_we_q   <= cap_we_d;
        cap_uns_q  <= cap_uns_d;
        cap_size_q <= cap_size_d;
        cap_off_q  <= cap_off_d;
        hi_word_q  <= hi_word_d;
        hi_be_q    <= hi_be_d;
        hi_wdata_q <= hi_wdata_d;
        rd_lo_q    <= rd_lo_d;
    end

    dmem_ram_bank #(
        .AddressWidth(AddressWidth),
        .DataWidth   (DataWidth)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (ram_we),
        .be_i   (ram_be),
        .addr_i (ram_addr),
        .wdata_i(ram_wdata),
        .rdata_o(ram_rdata)
    );

    // Low word comes from the beat-1 capture only when the response closes a split.
    assign merged = DataWidth'((rsp_split_q ? {ram_rdata, rd_lo_q}
                                            : {{DataWidth{1'b0}}, ram_rdata}) >> {cap_off_q, 3'b000});

    always_comb begin
        case (cap_size_q)
            SZ_B:    begin fill = merged[7];           nbits = 8;         end
            SZ_H:    begin fill = merged[15];          nbits = 16;        end
            SZ_W:    begin fill = merged[31];          nbits = 32;        end
            default: begin fill = merged[DataWidth-1]; nbits = DataWidth; end
        endcase
        fill = fill && !cap_uns_q;
        ext  = merged;
        for (int i = 0; i < DataWidth; i++) begin
            if (i >= nbits) ext[i] = fill;
        end
    end

    assign rsp_valid_o = rsp_pend_q;
    assign rsp_err_o   = rsp_pend_q && rsp_err_q;
    assign rsp_rdata_o = (rsp_pend_q && !rsp_err_q && !cap_we_q) ? ext : '0;

endmodule
